// File: rtl/soc_crc32_arb.sv
// Two-requester round-robin front end for a shared byte-serial CRC32 engine.
// A granted requester owns the engine for a whole message: the engine is
// cleared, each accepted word is fed one byte at a time through the engine's
// ready/process handshake, and the final CRC plus word count is returned.
module soc_crc32_arb #(
    parameter bit          LSB_BYTE_FIRST = 1'b1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [63:0]          req_data,
    input  logic [1:0]           req_last,
    input  logic [3:0]           req_nbytes,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [31:0]          rsp_crc,
    output logic [CNT_WIDTH-1:0] rsp_words,
    output logic                 busy,
    output logic                 eng_clear,
    output logic [7:0]           eng_data,
    output logic                 eng_process,
    input  logic                 eng_ready,
    input  logic [31:0]          eng_crc
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StWord,
        StFeed,
        StDrain,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_served_q, last_served_d;
    logic [31:0]          word_q, word_d;
    logic                 last_q, last_d;
    logic [2:0]           nbytes_q, nbytes_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 drain_wait_q, drain_wait_d;
    logic [31:0]          rsp_crc_q, rsp_crc_d;
    logic [CNT_WIDTH-1:0] rsp_words_q, rsp_words_d;

    logic [31:0]          cur_data;
    logic                 cur_last;
    logic [1:0]           cur_nbytes;
    logic [1:0]           byte_sel;
    logic [7:0]           cur_byte;

    // Select the granted requester's word fields and the byte to present.
    always_comb begin
        cur_data   = grant_q ? req_data[63:32]  : req_data[31:0];
        cur_last   = grant_q ? req_last[1]      : req_last[0];
        cur_nbytes = grant_q ? req_nbytes[3:2]  : req_nbytes[1:0];
        // MSB-first order walks the byte lanes downwards.
        byte_sel   = LSB_BYTE_FIRST ? byte_idx_q : ~byte_idx_q;
        cur_byte   = word_q[7:0];
        case (byte_sel)
            2'd0:    cur_byte = word_q[7:0];
            2'd1:    cur_byte = word_q[15:8];
            2'd2:    cur_byte = word_q[23:16];
            default: cur_byte = word_q[31:24];
        endcase
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        word_d        = word_q;
        last_d        = last_q;
        nbytes_d      = nbytes_q;
        byte_idx_d    = byte_idx_q;
        cnt_d         = cnt_q;
        drain_wait_d  = drain_wait_q;
        rsp_crc_d     = rsp_crc_q;
        rsp_words_d   = rsp_words_q;

        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        eng_clear   = 1'b0;
        eng_data    = 8'h00;
        eng_process = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid != 2'b00) begin
                    // On a tie the requester not served last time wins.
                    grant_d = (req_valid == 2'b11) ? ~last_served_q : req_valid[1];
                    state_d = StClear;
                end
            end

            StClear: begin
                eng_clear = 1'b1;
                cnt_d     = '0;
                state_d   = StWord;
            end

            StWord: begin
                req_ready[grant_q] = 1'b1;
                if (req_valid[grant_q]) begin
                    word_d     = cur_data;
                    last_d     = cur_last;
                    nbytes_d   = (cur_last && (cur_nbytes != 2'd0)) ? {1'b0, cur_nbytes} : 3'd4;
                    byte_idx_d = 2'd0;
                    cnt_d      = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    state_d    = StFeed;
                end
            end

            StFeed: begin
                eng_data    = cur_byte;
                eng_process = eng_ready;
                if (eng_ready) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if ({1'b0, byte_idx_q} == nbytes_q - 3'd1) begin
                        drain_wait_d = 1'b1;
                        state_d      = last_q ? StDrain : StWord;
                    end
                end
            end

            StDrain: begin
                // Engine ready still reflects the pre-strobe state for one cycle.
                if (drain_wait_q) begin
                    drain_wait_d = 1'b0;
                end else if (eng_ready) begin
                    rsp_crc_d   = eng_crc;
                    rsp_words_d = cnt_q;
                    state_d     = StDone;
                end
            end

            StDone: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    last_served_d = grant_q;
                    state_d       = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign rsp_crc   = rsp_crc_q;
    assign rsp_words = rsp_words_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            last_served_q <= 1'b1;
            word_q        <= '0;
            last_q        <= 1'b0;
            nbytes_q      <= 3'd4;
            byte_idx_q    <= 2'd0;
            cnt_q         <= '0;
            drain_wait_q  <= 1'b0;
            rsp_crc_q     <= '0;
            rsp_words_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            word_q        <= word_d;
            last_q        <= last_d;
            nbytes_q      <= nbytes_d;
            byte_idx_q    <= byte_idx_d;
            cnt_q         <= cnt_d;
            drain_wait_q  <= drain_wait_d;
            rsp_crc_q     <= rsp_crc_d;
            rsp_words_q   <= rsp_words_d;
        end
    end

endmodule

// File: tb/tb_soc_crc32_arb.sv
// Bench for soc_crc32_arb: a bit-serial CRC-32C engine stub, directed message
// stimulus, and a result scoreboard computed from the message bytes.
module tb_soc_crc32_arb;

    localparam int unsigned CW    = 3;
    localparam int          LIMIT = 3000;

    logic          clk = 1'b0;
    logic          res;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [63:0]   req_data;
    logic [1:0]    req_last;
    logic [3:0]    req_nbytes;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [31:0]   rsp_crc;
    logic [CW-1:0] rsp_words;
    logic          busy;
    logic          eng_clear;
    logic [7:0]    eng_data;
    logic          eng_process;
    logic          eng_ready;
    logic [31:0]   eng_crc;

    always #5 clk = ~clk;

    soc_crc32_arb #(
        .LSB_BYTE_FIRST(1'b1),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk        (clk),
        .res        (res),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_nbytes (req_nbytes),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_crc    (rsp_crc),
        .rsp_words  (rsp_words),
        .busy       (busy),
        .eng_clear  (eng_clear),
        .eng_data   (eng_data),
        .eng_process(eng_process),
        .eng_ready  (eng_ready),
        .eng_crc    (eng_crc)
    );

    // CRC-32C engine stub: one load cycle, then eight shift cycles per byte.
    logic [31:0] e_crc = 32'hFFFF_FFFF;
    int          e_cnt = 0;
    always @(posedge clk) begin
        if (eng_clear) begin
            e_crc <= 32'hFFFF_FFFF;
            e_cnt <= 0;
        end else if (eng_process) begin
            e_crc <= e_crc ^ {24'h0, eng_data};
            e_cnt <= 8;
        end else if (e_cnt > 0) begin
            e_crc <= e_crc[0] ? ((e_crc >> 1) ^ 32'h82F6_3B78) : (e_crc >> 1);
            e_cnt <= e_cnt - 1;
        end
    end
    assign eng_ready = (e_cnt == 0);
    assign eng_crc   = ~e_crc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected results, in completion order.
    typedef struct {
        int            who;
        logic [31:0]   crc;
        logic [CW-1:0] words;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          have_cur = 1'b0;
    logic [31:0] msg_w[32];
    int          pulse_cyc[$];
    logic [7:0]  pulse_dat[$];
    int          clear_cnt = 0;
    bit          prev_clear = 1'b0;
    int          last_acc_cyc = 0;
    int          rsp_cyc = 0;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'h82F6_3B78) : (r >> 1);
        return r;
    endfunction

    // Expected result for words msg_w[base +: n], last word holding nb bytes.
    task automatic push_expect(input int who, input int base, input int n, input int nb);
        exp_t        e;
        logic [31:0] c;
        logic [31:0] w;
        int          k;
        int          maxw;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            w = msg_w[base + i];
            k = (i == n - 1 && nb != 0) ? nb : 4;
            for (int j = 0; j < k; j++) c = crc_byte(c, w[8*j +: 8]);
        end
        maxw    = (1 << CW) - 1;
        e.who   = who;
        e.crc   = ~c;
        e.words = CW'((n > maxw) ? maxw : n);
        exp_q.push_back(e);
    endtask

    // Compare process: protocol invariants and results against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (res) begin
                have_cur   = 1'b0;
                prev_clear = 1'b0;
            end else begin
                if (eng_process) begin
                    pulse_cyc.push_back(cyc);
                    pulse_dat.push_back(eng_data);
                    check("process_without_ready", eng_ready, 1);
                    check("process_with_clear", eng_clear, 0);
                end
                if (eng_clear) begin
                    clear_cnt++;
                    check("clear_pulse_width", prev_clear, 0);
                end
                prev_clear = eng_clear;
                if (req_ready != 2'b00) check("req_ready_onehot", $countones(req_ready), 1);
                if (rsp_valid != 2'b00) begin
                    if (!have_cur) begin
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_rsp: got rsp_valid=%b, expected none", rsp_valid);
                        end else begin
                            cur      = exp_q.pop_front();
                            have_cur = 1'b1;
                        end
                    end
                    if (have_cur) begin
                        check("rsp_valid_owner", rsp_valid, 2'b01 << cur.who);
                        check("rsp_crc", rsp_crc, cur.crc);
                        check("rsp_words", rsp_words, cur.words);
                        check("busy_in_done", busy, 1);
                    end
                end else begin
                    have_cur = 1'b0;
                end
            end
        end
    end

    task automatic offer(input int who, input logic [31:0] w, input logic last, input int nb);
        req_data[32*who +: 32] = w;
        req_last[who]          = last;
        req_nbytes[2*who +: 2] = 2'(nb);
        req_valid[who]         = 1'b1;
    endtask

    task automatic wait_accept(input int who);
        int k;
        for (k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (req_ready[who]) break;
        end
        tests++;
        if (k == LIMIT) begin
            fails++;
            $display("FAIL accept_timeout: got no req_ready[%0d], expected acceptance", who);
        end else begin
            last_acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        req_valid[who] = 1'b0;
        req_last[who]  = 1'b0;
    endtask

    task automatic send_msg(input int who, input int base, input int n, input int nb);
        for (int i = 0; i < n; i++) begin
            offer(who, msg_w[base + i], i == n - 1, nb);
            wait_accept(who);
        end
    endtask

    // Wait for rsp_valid[who]; optionally require the other port stays unserved.
    task automatic wait_valid(input int who, input bit chk_other);
        int k;
        for (k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            if (rsp_valid[who]) break;
            if (chk_other) check("other_ready_held_low", req_ready[1 - who], 0);
        end
        tests++;
        if (k == LIMIT) begin
            fails++;
            $display("FAIL rsp_timeout: got no rsp_valid[%0d], expected a result", who);
        end
        rsp_cyc = cyc;
    endtask

    task automatic consume(input int who);
        rsp_ready[who] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[who] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res       = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_eng_process", eng_process, 0);
        check("rst_eng_clear", eng_clear, 0);
        res = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected bench to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        res        = 1'b1;
        req_valid  = 2'b00;
        req_data   = '0;
        req_last   = 2'b00;
        req_nbytes = '0;
        rsp_ready  = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_crc", rsp_crc, 0);
        check("reset_rsp_words", rsp_words, 0);
        check("reset_eng_clear", eng_clear, 0);
        check("reset_eng_process", eng_process, 0);
        check("reset_eng_data", eng_data, 0);
        check("reset_busy", busy, 0);
        res = 1'b0;

        // "123456789" from requester 0.
        msg_w[0] = 32'h3433_3231;
        msg_w[1] = 32'h3837_3635;
        msg_w[2] = 32'h0000_0039;
        push_expect(0, 0, 3, 1);
        send_msg(0, 0, 3, 1);
        wait_valid(0, 1'b0);
        check("t1_valid", rsp_valid, 2'b01);
        check("t1_crc_literal", rsp_crc, 32'hE306_9283);
        check("t1_words_literal", rsp_words, 3);
        consume(0);

        // Single-byte message.
        msg_w[4] = 32'h0000_0031;
        pulse_cyc.delete();
        pulse_dat.delete();
        push_expect(0, 4, 1, 1);
        send_msg(0, 4, 1, 1);
        wait_valid(0, 1'b0);
        check("one_byte_pulses", pulse_cyc.size(), 1);
        if (pulse_dat.size() > 0) check("one_byte_data", pulse_dat[0], 8'h31);
        check("one_byte_crc_literal", rsp_crc, 32'h90F5_99E3);
        check("one_byte_words", rsp_words, 1);
        consume(0);

        // Four-byte last word: pulse spacing and total latency.
        msg_w[5] = 32'h6463_6261;
        pulse_cyc.delete();
        pulse_dat.delete();
        push_expect(0, 5, 1, 0);
        send_msg(0, 5, 1, 0);
        wait_valid(0, 1'b0);
        check("timing_pulses", pulse_cyc.size(), 4);
        if (pulse_cyc.size() == 4) begin
            check("timing_first_pulse", pulse_cyc[0] - last_acc_cyc, 1);
            for (int i = 1; i < 4; i++) check("timing_spacing", pulse_cyc[i] - pulse_cyc[i-1], 9);
            check("timing_order", {pulse_dat[0], pulse_dat[1], pulse_dat[2], pulse_dat[3]},
                  32'h6162_6364);
        end
        check("timing_latency", rsp_cyc - last_acc_cyc, 38);
        consume(0);

        // Arbitration after reset: tie goes to requester 0, then 1 is served.
        do_reset();
        msg_w[8] = 32'h0000_00AA;
        msg_w[9] = 32'h0000_00BB;
        msg_w[10] = 32'h1122_3344;
        push_expect(0, 8, 1, 1);
        push_expect(1, 9, 1, 1);
        @(negedge clk);
        offer(0, msg_w[8], 1'b1, 1);
        offer(1, msg_w[9], 1'b1, 1);
        wait_accept(0);
        wait_valid(0, 1'b1);
        consume(0);
        wait_accept(1);
        wait_valid(1, 1'b0);
        consume(1);

        // Tie again after serving 1: requester 0 wins; then hold DONE with 1 waiting.
        push_expect(0, 8, 1, 1);
        push_expect(1, 9, 1, 1);
        push_expect(0, 10, 1, 0);
        @(negedge clk);
        offer(0, msg_w[8], 1'b1, 1);
        offer(1, msg_w[9], 1'b1, 1);
        wait_accept(0);
        wait_valid(0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_no_ready", req_ready, 0);
            check("hold_valid", rsp_valid, 2'b01);
        end
        // Requester 0 re-requests before consuming; 1 must still win the tie.
        offer(0, msg_w[10], 1'b1, 0);
        consume(0);
        wait_accept(1);
        wait_valid(1, 1'b1);
        consume(1);
        wait_accept(0);
        wait_valid(0, 1'b0);
        consume(0);

        // Reset in the middle of FEED, then a clean message.
        offer(0, msg_w[0], 1'b0, 0);
        wait_accept(0);
        repeat (12) @(negedge clk);
        do_reset();
        clear_cnt = 0;
        push_expect(0, 0, 3, 1);
        send_msg(0, 0, 3, 1);
        wait_valid(0, 1'b0);
        check("post_reset_clear_seen", clear_cnt, 1);
        check("post_reset_crc_literal", rsp_crc, 32'hE306_9283);
        consume(0);

        // Word counter saturates at 2^CW-1.
        for (int i = 0; i < 9; i++) msg_w[12 + i] = 32'hA5A5_0000 + 32'(i * 32'h0101);
        push_expect(1, 12, 9, 2);
        send_msg(1, 12, 9, 2);
        wait_valid(1, 1'b0);
        check("sat_words_literal", rsp_words, 7);
        consume(1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("idle_at_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/soc_crc32_arb.md
Name: soc_crc32_arb

Overview:
Shares one byte-wide, bit-serial CRC32 engine between two requesters at message granularity. A requester streams 32-bit words into the arbiter, which clears the engine, feeds the message bytes one at a time with the engine's ready/process handshake, and returns the final CRC plus a word count. Once a requester is granted, it holds the engine until its message completes. Arbitration is round-robin. The block sits between the SoC bus-side CRC peripheral registers (or a DMA client) and the CRC engine instance.

Parameters:
LSB_BYTE_FIRST, 1, 1: feed byte 0 (bits 7:0) of each word first; 0: feed bits 31:24 first.
CNT_WIDTH, 16, width of the per-message word counter; the counter saturates at all-ones.

Ports:
clk  in  1  system clock
res  in  1  asynchronous, active-high reset
req_valid  in  2  per requester: a word is offered
req_ready  out  2  per requester: the word is accepted this cycle (valid&ready)
req_data  in  64  packed words; requester i uses [32i+31:32i]
req_last  in  2  offered word is the final word of the message
req_nbytes  in  4  packed 2 bits per requester: valid bytes in the last word; 0 means 4; ignored when last=0
rsp_valid  out  2  one-hot: result ready for requester i
rsp_ready  in  2  requester i takes the result
rsp_crc  out  32  result CRC (engine output, captured)
rsp_words  out  CNT_WIDTH  number of words accepted in the message
busy  out  1  high in every state except IDLE
eng_clear  out  1  synchronous clear pulse driven to the engine's reset input
eng_data  out  8  byte presented to the engine
eng_process  out  1  byte strobe to the engine
eng_ready  in  1  engine idle
eng_crc  in  32  engine's final-XORed CRC output

Behaviour:
- Reset (asynchronous): state=IDLE; req_ready=0, rsp_valid=0, rsp_crc=0, rsp_words=0, eng_clear=0, eng_process=0, eng_data=0, busy=0; last_served=1, so requester 0 wins the first tie.
- State machine: IDLE -> CLEAR -> WORD -> FEED -> (WORD | DRAIN) -> DONE -> IDLE.
- IDLE: if exactly one req_valid is high, grant that requester. If both are high, grant the requester that is not last_served. Register the grant and go to CLEAR. No word is accepted in IDLE.
- CLEAR: eng_clear=1 for exactly one cycle; clear the word counter; go to WORD.
- WORD: req_ready[g]=1 combinationally from state; the other requester's req_ready stays 0.
  - On req_valid[g], latch the data and last flag. Set the byte count to 4, or to nbytes (0 meaning 4) when last=1. Increment the word counter (saturating). Go to FEED.
- FEED: eng_process=eng_ready, with eng_data set to the current byte.
  - Byte order: LSB_BYTE_FIRST=1 sends byte0..3; LSB_BYTE_FIRST=0 sends byte3..0.
  - In each cycle where eng_process=1, advance the byte index. The engine deasserts ready the following cycle, so the same byte is never issued twice.
  - After the last byte is issued: go to DRAIN if last=1, otherwise go to WORD.
- Timing: each byte costs 9 cycles (1 load + 8 shifts). A full word costs 36 cycles of engine time.
- DRAIN: wait one cycle for ready to fall, then wait for eng_ready=1. Capture rsp_crc<=eng_crc and rsp_words<=counter, then go to DONE.
- DONE: rsp_valid[g]=1, with rsp_crc and rsp_words held stable. On rsp_ready[g]: set last_served<=g and go to IDLE. rsp_ready of the other requester is ignored.
- Boundaries:
  - A request arriving on the other port during a message waits; it is never accepted mid-message.
  - req_valid dropping in WORD stalls the arbiter indefinitely, with the engine idle.
  - A 1-byte message (single word, last=1, nbytes=1) is legal. Zero-byte messages are impossible.
  - The counter saturates at 2^CNT_WIDTH-1.
  - Reset mid-message abandons it. The engine is not cleared by res, but the next message always passes through CLEAR first.
  - eng_process is never high outside FEED; eng_clear is never high outside CLEAR.

Test Plan:
- Requester 0 sends 0x34333231, 0x38373635, then 0x00000039 (last=1, nbytes=1) with CRC-32C engine defaults -> rsp_valid=01, rsp_crc=0xE3069283, rsp_words=3.
- Both requesters valid in the same cycle after reset -> requester 0 granted, requester 1's req_ready held 0 until requester 0's result is consumed. Requester 1 is then granted. With both valid again, requester 0 wins next.
- Single word 0x00000031 (last=1, nbytes=1) -> exactly one eng_process pulse with eng_data=0x31. rsp_crc=CRC-32C("1")=0x90F599E3.
- Timing: count cycles from word acceptance to rsp_valid for a 4-byte last word -> exactly 4 eng_process pulses, each preceded by eng_ready=1 and 9 cycles apart.
- Assert res while in FEED, then run the "123456789" message -> CLEAR pulse observed, result 0xE3069283 (no stale state).
- Hold rsp_ready low for 20 cycles in DONE with the other req_valid high -> rsp_crc and rsp_words stable, no grant change, no req_ready high.
